alu_issue_arbiter: RTL and testbench

Shares the single execute-stage ALU between two requesters (port 0: main integer pipeline; port 1: secondary issue slot, e.g. address/branch helper). Decodes each request's opcode/funct3/funct7[5] into the team's 4-bit ALU operation code and applies round-robin arbitration. It drives the combinational ALU and captures the result in a one-entry output register with valid/ready backpressure. Sits between the issue logic and the writeback/bypass network.

---
 rtl/alu_issue_arbiter.sv | 154 +++++++++++++++
 tb/tb_alu_issue_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_arbiter.sv
// Two-port round-robin issue arbiter in front of a shared combinational ALU.
// The granted request is decoded, and its ALU result is captured into a one-entry result register.
module alu_issue_arbiter #(
    parameter int XLEN = 32,
    parameter int TAGW = 4
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [6:0]      req0_opcode,
    input  logic [2:0]      req0_funct3,
    input  logic            req0_funct7b5,
    input  logic [XLEN-1:0] req0_a,
    input  logic [XLEN-1:0] req0_b,
    input  logic [TAGW-1:0] req0_tag,

    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [6:0]      req1_opcode,
    input  logic [2:0]      req1_funct3,
    input  logic            req1_funct7b5,
    input  logic [XLEN-1:0] req1_a,
    input  logic [XLEN-1:0] req1_b,
    input  logic [TAGW-1:0] req1_tag,

    output logic [3:0]      alu_op,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    input  logic [XLEN-1:0] alu_result,

    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic            rsp_port,
    output logic [TAGW-1:0] rsp_tag
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_t;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_AND  = 4'b0001;
    localparam logic [3:0] OP_OR   = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_SLT  = 4'b0110;
    localparam logic [3:0] OP_SLTU = 4'b0111;

    localparam logic [6:0] OPC_R = 7'b0110011;
    localparam logic [6:0] OPC_I = 7'b0010011;

    // Immediate forms have no SUB; bit 30 only selects SRA there.
    function automatic logic [3:0] decode(input logic [6:0] opcode,
                                          input logic [2:0] funct3,
                                          input logic       funct7b5);
        logic [3:0] op;
        logic       is_r;
        op   = OP_ADD;
        is_r = (opcode == OPC_R);
        if (is_r || opcode == OPC_I) begin
            case (funct3)
                3'b000:  op = (is_r && funct7b5) ? OP_SUB : OP_ADD;
                3'b001:  op = OP_SLL;
                3'b010:  op = OP_SLT;
                3'b011:  op = OP_SLTU;
                3'b100:  op = OP_XOR;
                3'b101:  op = funct7b5 ? OP_SRA : OP_SRL;
                3'b110:  op = OP_OR;
                default: op = OP_AND;
            endcase
        end
        return op;
    endfunction

    slot_t      state;
    slot_t      state_next;
    logic       last_grant;
    logic       grant;
    logic       any_valid;
    logic       slot_free;
    logic       accept;
    logic [3:0] op0;
    logic [3:0] op1;

    assign op0 = decode(req0_opcode, req0_funct3, req0_funct7b5);
    assign op1 = decode(req1_opcode, req1_funct3, req1_funct7b5);

    assign any_valid = req0_valid | req1_valid;
    assign grant     = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    assign rsp_valid = (state == FULL);
    // Only rsp_ready can free a full slot combinationally; no path from rsp_valid's next value.
    assign slot_free = (state == EMPTY) | (rsp_valid & rsp_ready);
    assign accept    = slot_free & any_valid;

    assign req0_ready = slot_free & req0_valid & ~grant;
    assign req1_ready = slot_free & req1_valid & grant;

    always_comb begin
        alu_op = OP_ADD;
        alu_a  = '0;
        alu_b  = '0;
        if (any_valid) begin
            if (grant) begin
                alu_op = op1;
                alu_a  = req1_a;
                alu_b  = req1_b;
            end else begin
                alu_op = op0;
                alu_a  = req0_a;
                alu_b  = req0_b;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY:   if (accept) state_next = FULL;
            FULL:    if (rsp_ready && !accept) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    // last_grant resets to 1 so port 0 wins the first contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_data   <= '0;
            rsp_port   <= 1'b0;
            rsp_tag    <= '0;
            last_grant <= 1'b1;
        end else if (accept) begin
            rsp_data   <= alu_result;
            rsp_port   <= grant;
            rsp_tag    <= grant ? req1_tag : req0_tag;
            last_grant <= grant;
        end
    end

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Self-checking bench for alu_issue_arbiter: behavioural ALU model plus a result scoreboard.
module tb_alu_issue_arbiter;

    localparam int XLEN = 32;
    localparam int TAGW = 4;

    logic            clk;
    logic            rst;
    logic            req0_valid, req1_valid;
    logic            req0_ready, req1_ready;
    logic [6:0]      req0_opcode, req1_opcode;
    logic [2:0]      req0_funct3, req1_funct3;
    logic            req0_funct7b5, req1_funct7b5;
    logic [XLEN-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [TAGW-1:0] req0_tag, req1_tag;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] alu_a, alu_b, alu_result;
    logic            rsp_valid, rsp_ready;
    logic [XLEN-1:0] rsp_data;
    logic            rsp_port;
    logic [TAGW-1:0] rsp_tag;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic            port;
        logic [TAGW-1:0] tag;
        logic [XLEN-1:0] data;
    } exp_t;

    exp_t sb[$];

    alu_issue_arbiter #(.XLEN(XLEN), .TAGW(TAGW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
        .req0_funct3(req0_funct3), .req0_funct7b5(req0_funct7b5),
        .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
        .req1_funct3(req1_funct3), .req1_funct7b5(req1_funct7b5),
        .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_port(rsp_port), .rsp_tag(rsp_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [XLEN-1:0] alu_fn(input logic [3:0] op,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
        case (op)
            4'b1000: return a - b;
            4'b0001: return a & b;
            4'b0010: return a | b;
            4'b0011: return a ^ b;
            4'b0100: return a << b[4:0];
            4'b0101: return a >> b[4:0];
            4'b1101: return $unsigned($signed(a) >>> b[4:0]);
            4'b0110: return {31'b0, $signed(a) < $signed(b)};
            4'b0111: return {31'b0, a < b};
            default: return a + b;
        endcase
    endfunction

    function automatic logic [3:0] ref_decode(input logic [6:0] opc,
                                              input logic [2:0] f3,
                                              input logic       f7);
        logic [3:0] tbl[8];
        if (opc != 7'b0110011 && opc != 7'b0010011) return 4'b0000;
        tbl = '{4'b0000, 4'b0100, 4'b0110, 4'b0111, 4'b0011, 4'b0101, 4'b0010, 4'b0001};
        if (f3 == 3'b000 && opc == 7'b0110011 && f7) return 4'b1000;
        if (f3 == 3'b101 && f7) return 4'b1101;
        return tbl[f3];
    endfunction

    // Shared ALU stand-in, driven purely by the DUT's ALU outputs.
    always_comb alu_result = alu_fn(alu_op, alu_a, alu_b);

    // Handshakes are observed mid-cycle; results loaded at the next edge are pushed after the pop.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
        end else begin
            if (rsp_valid && rsp_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL sb_underflow: got rsp port=%0d tag=%0d data=%h, expected none",
                             rsp_port, rsp_tag, rsp_data);
                end else begin
                    e = sb.pop_front();
                    if ({rsp_port, rsp_tag, rsp_data} !== {e.port, e.tag, e.data}) begin
                        n_fail++;
                        $display("[TB] FAIL sb_result: got port=%0d tag=%0d data=%h, expected port=%0d tag=%0d data=%h",
                                 rsp_port, rsp_tag, rsp_data, e.port, e.tag, e.data);
                    end
                end
            end
            if (req0_valid && req0_ready)
                sb.push_back('{1'b0, req0_tag,
                    alu_fn(ref_decode(req0_opcode, req0_funct3, req0_funct7b5), req0_a, req0_b)});
            if (req1_valid && req1_ready)
                sb.push_back('{1'b1, req1_tag,
                    alu_fn(ref_decode(req1_opcode, req1_funct3, req1_funct7b5), req1_a, req1_b)});
        end
    end

    task automatic set_req0(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                            input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                            input logic [TAGW-1:0] tag);
        req0_valid = 1'b1; req0_opcode = opc; req0_funct3 = f3; req0_funct7b5 = f7;
        req0_a = a; req0_b = b; req0_tag = tag;
    endtask

    task automatic set_req1(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                            input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                            input logic [TAGW-1:0] tag);
        req1_valid = 1'b1; req1_opcode = opc; req1_funct3 = f3; req1_funct7b5 = f7;
        req1_a = a; req1_b = b; req1_tag = tag;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b0; req0_opcode = '0; req0_funct3 = '0; req0_funct7b5 = 1'b0;
        req0_a = '0; req0_b = '0; req0_tag = '0;
        req1_valid = 1'b0; req1_opcode = '0; req1_funct3 = '0; req1_funct7b5 = 1'b0;
        req1_a = '0; req1_b = '0; req1_tag = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++;
        if ({rsp_valid, rsp_port, rsp_tag, rsp_data} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_rsp: got valid=%0d port=%0d tag=%0d data=%h, expected all zero",
                     rsp_valid, rsp_port, rsp_tag, rsp_data);
        end
        n_checks++;
        if ({req0_ready, req1_ready, alu_op, alu_a, alu_b} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_idle: got r0=%0d r1=%0d op=%b a=%h b=%h, expected zeros",
                     req0_ready, req1_ready, alu_op, alu_a, alu_b);
        end
    endtask

    task automatic test_single_add();
        @(posedge clk); #1;
        set_req0(7'b0110011, 3'b000, 1'b0, 32'd5, 32'd7, 4'd3);
        #1;
        n_checks++;
        if ({req0_ready, req1_ready, alu_op} !== {1'b1, 1'b0, 4'b0000}) begin
            n_fail++;
            $display("[TB] FAIL add_ready: got r0=%0d r1=%0d op=%b, expected 1 0 0000",
                     req0_ready, req1_ready, alu_op);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        n_checks++;
        if ({rsp_valid, rsp_data, rsp_port, rsp_tag} !== {1'b1, 32'd12, 1'b0, 4'd3}) begin
            n_fail++;
            $display("[TB] FAIL add_rsp: got valid=%0d data=%0d port=%0d tag=%0d, expected 1 12 0 3",
                     rsp_valid, rsp_data, rsp_port, rsp_tag);
        end
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [6:0]      opc;
        logic [2:0]      f3;
        logic            f7;
        logic [3:0]      op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
    } dec_vec_t;

    task automatic test_decode();
        dec_vec_t v[12];
        v = '{
            '{7'b0110011, 3'b000, 1'b1, 4'b1000, 32'd20,         32'd7},
            '{7'b0010011, 3'b000, 1'b1, 4'b0000, 32'd20,         32'd7},
            '{7'b0010011, 3'b101, 1'b1, 4'b1101, 32'hF000_0000, 32'd4},
            '{7'b0000011, 3'b000, 1'b0, 4'b0000, 32'd3,          32'd4},
            '{7'b0110011, 3'b101, 1'b0, 4'b0101, 32'hF000_0000, 32'd4},
            '{7'b0110011, 3'b010, 1'b0, 4'b0110, 32'hFFFF_FFFF, 32'd1},
            '{7'b0110011, 3'b011, 1'b0, 4'b0111, 32'hFFFF_FFFF, 32'd1},
            '{7'b0010011, 3'b001, 1'b0, 4'b0100, 32'd1,          32'd31},
            '{7'b0110011, 3'b100, 1'b0, 4'b0011, 32'hA5A5_0F0F, 32'hFFFF_0000},
            '{7'b0110011, 3'b110, 1'b0, 4'b0010, 32'h1200_0034, 32'h0056_7800},
            '{7'b0110011, 3'b111, 1'b0, 4'b0001, 32'hF0F0_F0F0, 32'h3C3C_3C3C},
            '{7'b0110011, 3'b101, 1'b1, 4'b1101, 32'h8000_0010, 32'd35}
        };
        for (int i = 0; i < 12; i++) begin
            set_req1(v[i].opc, v[i].f3, v[i].f7, v[i].a, v[i].b, 4'(i));
            #1;
            n_checks++;
            if ({req1_ready, alu_op, alu_a, alu_b} !== {1'b1, v[i].op, v[i].a, v[i].b}) begin
                n_fail++;
                $display("[TB] FAIL decode_%0d: got r1=%0d op=%b a=%h b=%h, expected 1 %b %h %h",
                         i, req1_ready, alu_op, alu_a, alu_b, v[i].op, v[i].a, v[i].b);
            end
            @(posedge clk); #1;
        end
        req1_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic exp_port;
        do_reset();
        rsp_ready = 1'b1;
        set_req0(7'b0010011, 3'b000, 1'b0, 32'd100, 32'd0, 4'd0);
        set_req1(7'b0110011, 3'b000, 1'b1, 32'd200, 32'd0, 4'd8);
        for (int i = 0; i < 6; i++) begin
            exp_port = i[0];
            #1;
            n_checks++;
            if ({req0_ready, req1_ready} !== {~exp_port, exp_port}) begin
                n_fail++;
                $display("[TB] FAIL rr_ready_%0d: got r0=%0d r1=%0d, expected port %0d",
                         i, req0_ready, req1_ready, exp_port);
            end
            @(posedge clk); #1;
            n_checks++;
            if ({rsp_valid, rsp_port} !== {1'b1, exp_port}) begin
                n_fail++;
                $display("[TB] FAIL rr_port_%0d: got valid=%0d port=%0d, expected 1 %0d",
                         i, rsp_valid, rsp_port, exp_port);
            end
            if (exp_port) begin
                req1_tag = req1_tag + 4'd1; req1_b = req1_b + 32'd3;
            end else begin
                req0_tag = req0_tag + 4'd1; req0_b = req0_b + 32'd5;
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        set_req0(7'b0010011, 3'b000, 1'b0, 32'd100, 32'd1, 4'd8);
        set_req1(7'b0110011, 3'b000, 1'b1, 32'd50, 32'd8, 4'd9);
        #1;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL bp_first: got r0=%0d r1=%0d, expected 1 0", req0_ready, req1_ready);
        end
        @(posedge clk); #1;
        set_req0(7'b0110011, 3'b100, 1'b0, 32'h0000_00FF, 32'h0000_0F0F, 4'd10);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if ({req0_ready, req1_ready, rsp_valid, rsp_data, rsp_port, rsp_tag} !==
                {1'b0, 1'b0, 1'b1, 32'd101, 1'b0, 4'd8}) begin
                n_fail++;
                $display("[TB] FAIL bp_hold_%0d: got r0=%0d r1=%0d v=%0d data=%0d port=%0d tag=%0d, expected 0 0 1 101 0 8",
                         i, req0_ready, req1_ready, rsp_valid, rsp_data, rsp_port, rsp_tag);
            end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        #1;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            n_fail++;
            $display("[TB] FAIL bp_release: got r0=%0d r1=%0d, expected 0 1", req0_ready, req1_ready);
        end
        @(posedge clk); #1;
        req1_valid = 1'b0;
        n_checks++;
        if ({rsp_valid, rsp_port, rsp_data} !== {1'b1, 1'b1, 32'd42}) begin
            n_fail++;
            $display("[TB] FAIL bp_reload: got v=%0d port=%0d data=%0d, expected 1 1 42",
                     rsp_valid, rsp_port, rsp_data);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        n_checks++;
        if ({rsp_port, rsp_tag, rsp_data} !== {1'b0, 4'd10, 32'h0000_0FF0}) begin
            n_fail++;
            $display("[TB] FAIL bp_next: got port=%0d tag=%0d data=%h, expected 0 10 00000ff0",
                     rsp_port, rsp_tag, rsp_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midflight();
        rsp_ready = 1'b0;
        set_req0(7'b0010011, 3'b000, 1'b0, 32'd1, 32'd1, 4'd1);
        set_req1(7'b0010011, 3'b000, 1'b0, 32'd2, 32'd2, 4'd2);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({rsp_valid, rsp_data} !== '0) begin
            n_fail++;
            $display("[TB] FAIL midreset_clear: got v=%0d data=%h, expected 0 0", rsp_valid, rsp_data);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        rsp_ready = 1'b1;
        #1;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL midreset_grant: got r0=%0d r1=%0d, expected 1 0", req0_ready, req1_ready);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        n_checks++;
        if ({rsp_valid, rsp_port, rsp_tag} !== {1'b1, 1'b0, 4'd1}) begin
            n_fail++;
            $display("[TB] FAIL midreset_rsp: got v=%0d port=%0d tag=%0d, expected 1 0 1",
                     rsp_valid, rsp_port, rsp_tag);
        end
        @(posedge clk); #1;
        req1_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (sb.size() != 0 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL drain: got pending=%0d v=%0d, expected 0 0", sb.size(), rsp_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_decode();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
